// File: rtl/response_arbiter.sv
// Response channel arbiter: hands the single upstream param/done channel to the unit serving
// the current command or to a round-robin-selected involuntary requester, with a frame watchdog.
module response_arbiter #(
    parameter int         NUNITS       = 4,
    parameter int         UNIT_BITS    = 4,
    parameter int         TIMEOUT      = 65535,
    parameter logic [7:0] RSP_BAD_UNIT = 8'hfe,
    parameter logic [7:0] RSP_TIMEOUT  = 8'hff
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  i_cmd_ready,
    input  logic [UNIT_BITS-1:0]  i_cmd_unit,
    output logic                  o_cmd_ack,
    output logic [NUNITS-1:0]     o_unit_cmd_ready,
    input  logic [32*NUNITS-1:0]  i_unit_param_data,
    input  logic [NUNITS-1:0]     i_unit_param_write,
    input  logic [NUNITS-1:0]     i_unit_done,
    input  logic [NUNITS-1:0]     i_unit_invol_req,
    output logic [NUNITS-1:0]     o_unit_invol_grant,
    output logic [31:0]           o_param_data,
    output logic                  o_param_write,
    output logic                  o_rsp_done,
    output logic                  o_rsp_invol,
    output logic                  o_rsp_err,
    output logic                  o_busy
);
    typedef enum logic [1:0] {
        S_IDLE  = 2'd0,
        S_CMD   = 2'd1,
        S_INVOL = 2'd2,
        S_ERR   = 2'd3
    } state_t;

    state_t            r_state;
    state_t            w_state_nxt;
    logic [3:0]        r_owner;
    logic [3:0]        r_rr;
    logic [15:0]       r_wdog;
    logic [7:0]        r_code;
    logic              r_err_invol;
    logic              r_cmd_ack;
    logic [NUNITS-1:0] r_unit_cmd_ready;
    logic [NUNITS-1:0] r_grant;
    logic [31:0]       r_param_data;
    logic              r_param_write;
    logic              r_rsp_done;
    logic              r_rsp_invol;
    logic              r_rsp_err;
    logic              r_busy;

    logic              w_own_write;
    logic              w_own_done;
    logic [31:0]       w_own_data;
    logic              w_cmd_ok;
    logic [3:0]        w_cmd_idx;
    logic [NUNITS-1:0] w_cmd_onehot;
    logic              w_req_any;
    logic [3:0]        w_pick;
    logic [NUNITS-1:0] w_pick_onehot;
    logic [4:0]        w_dist;
    logic [4:0]        w_best;
    logic              w_take;
    logic              w_wdog_hit;

    logic              w_cmd_ack_nxt;
    logic [NUNITS-1:0] w_ucr_nxt;
    logic [NUNITS-1:0] w_grant_nxt;
    logic [31:0]       w_pdata_nxt;
    logic              w_pwrite_nxt;
    logic              w_done_nxt;
    logic              w_invol_nxt;
    logic              w_err_nxt;
    logic [3:0]        w_owner_nxt;
    logic [3:0]        w_rr_nxt;
    logic [15:0]       w_wdog_nxt;
    logic [7:0]        w_code_nxt;
    logic              w_err_invol_nxt;

    // Select the current owner's strobes and data; every other unit is invisible.
    always_comb begin
        w_own_write = 1'b0;
        w_own_done  = 1'b0;
        w_own_data  = 32'd0;
        for (int i = 0; i < NUNITS; i++) begin
            w_own_write |= (r_owner == 4'(i)) & i_unit_param_write[i];
            w_own_done  |= (r_owner == 4'(i)) & i_unit_done[i];
            w_own_data  |= {32{r_owner == 4'(i)}} & i_unit_param_data[32*i +: 32];
        end
    end

    // Command decode and round-robin pick (smallest modular distance from r_rr wins).
    always_comb begin
        w_cmd_ok      = (32'(i_cmd_unit) < NUNITS);
        w_cmd_idx     = 4'(i_cmd_unit);
        w_cmd_onehot  = '0;
        w_req_any     = |i_unit_invol_req;
        w_pick        = 4'd0;
        w_pick_onehot = '0;
        w_best        = 5'h1f;
        w_dist        = 5'd0;
        w_take        = 1'b0;
        for (int i = 0; i < NUNITS; i++) begin
            w_cmd_onehot[i] = w_cmd_ok & (w_cmd_idx == 4'(i));
            w_dist = (5'(i) >= {1'b0, r_rr}) ? (5'(i) - {1'b0, r_rr})
                                              : (5'(i) + 5'(NUNITS) - {1'b0, r_rr});
            w_take = i_unit_invol_req[i] & (w_dist < w_best);
            w_pick = w_take ? 4'(i) : w_pick;
            w_best = w_take ? w_dist : w_best;
        end
        for (int i = 0; i < NUNITS; i++) begin
            w_pick_onehot[i] = (w_pick == 4'(i));
        end
        w_wdog_hit = (r_wdog == 16'(TIMEOUT));
    end

    // State register.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_state <= S_IDLE;
        end else begin
            r_state <= w_state_nxt;
        end
    end

    // Next-state logic; owner done beats an owner write, which beats the watchdog.
    always_comb begin
        w_state_nxt = r_state;
        case (r_state)
            S_IDLE: begin
                if (i_cmd_ready) begin
                    w_state_nxt = w_cmd_ok ? S_CMD : S_ERR;
                end else if (w_req_any) begin
                    w_state_nxt = S_INVOL;
                end else begin
                    w_state_nxt = S_IDLE;
                end
            end
            S_CMD, S_INVOL: begin
                if (w_own_done) begin
                    w_state_nxt = S_IDLE;
                end else if (!w_own_write && w_wdog_hit) begin
                    w_state_nxt = S_ERR;
                end else begin
                    w_state_nxt = r_state;
                end
            end
            S_ERR:   w_state_nxt = S_IDLE;
            default: w_state_nxt = S_IDLE;
        endcase
    end

    // Output/datapath next values, registered below.
    always_comb begin
        w_cmd_ack_nxt   = 1'b0;
        w_ucr_nxt       = '0;
        w_grant_nxt     = '0;
        w_pdata_nxt     = 32'd0;
        w_pwrite_nxt    = 1'b0;
        w_done_nxt      = 1'b0;
        w_invol_nxt     = 1'b0;
        w_err_nxt       = 1'b0;
        w_owner_nxt     = r_owner;
        w_rr_nxt        = r_rr;
        w_wdog_nxt      = 16'd0;
        w_code_nxt      = r_code;
        w_err_invol_nxt = r_err_invol;
        case (r_state)
            S_IDLE: begin
                if (i_cmd_ready) begin
                    w_cmd_ack_nxt   = 1'b1;
                    w_ucr_nxt       = w_cmd_onehot;
                    w_owner_nxt     = w_cmd_idx;
                    w_code_nxt      = RSP_BAD_UNIT;
                    w_err_invol_nxt = 1'b0;
                end else if (w_req_any) begin
                    w_grant_nxt = w_pick_onehot;
                    w_owner_nxt = w_pick;
                    w_invol_nxt = 1'b1;
                    w_rr_nxt    = (w_pick == 4'(NUNITS - 1)) ? 4'd0 : (w_pick + 4'd1);
                end else begin
                    w_owner_nxt = r_owner;
                end
            end
            S_CMD, S_INVOL: begin
                w_invol_nxt = (r_state == S_INVOL);
                if (w_own_done) begin
                    w_done_nxt  = 1'b1;
                    w_pdata_nxt = w_own_data;
                end else if (w_own_write) begin
                    w_pwrite_nxt = 1'b1;
                    w_pdata_nxt  = w_own_data;
                    w_grant_nxt  = r_grant;
                end else if (w_wdog_hit) begin
                    w_code_nxt      = RSP_TIMEOUT;
                    w_err_invol_nxt = (r_state == S_INVOL);
                end else begin
                    w_grant_nxt = r_grant;
                    w_wdog_nxt  = r_wdog + 16'd1;
                end
            end
            S_ERR: begin
                w_done_nxt  = 1'b1;
                w_err_nxt   = 1'b1;
                w_pdata_nxt = {24'd0, r_code};
                w_invol_nxt = r_err_invol;
            end
            default: begin
                w_owner_nxt = 4'd0;
            end
        endcase
    end

    // Registered outputs and datapath state.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_cmd_ack        <= 1'b0;
            r_unit_cmd_ready <= '0;
            r_grant          <= '0;
            r_param_data     <= 32'd0;
            r_param_write    <= 1'b0;
            r_rsp_done       <= 1'b0;
            r_rsp_invol      <= 1'b0;
            r_rsp_err        <= 1'b0;
            r_busy           <= 1'b0;
            r_owner          <= 4'd0;
            r_rr             <= 4'd0;
            r_wdog           <= 16'd0;
            r_code           <= 8'd0;
            r_err_invol      <= 1'b0;
        end else begin
            r_cmd_ack        <= w_cmd_ack_nxt;
            r_unit_cmd_ready <= w_ucr_nxt;
            r_grant          <= w_grant_nxt;
            r_param_data     <= w_pdata_nxt;
            r_param_write    <= w_pwrite_nxt;
            r_rsp_done       <= w_done_nxt;
            r_rsp_invol      <= w_invol_nxt;
            r_rsp_err        <= w_err_nxt;
            r_busy           <= (w_state_nxt != S_IDLE);
            r_owner          <= w_owner_nxt;
            r_rr             <= w_rr_nxt;
            r_wdog           <= w_wdog_nxt;
            r_code           <= w_code_nxt;
            r_err_invol      <= w_err_invol_nxt;
        end
    end

    assign o_cmd_ack          = r_cmd_ack;
    assign o_unit_cmd_ready   = r_unit_cmd_ready;
    assign o_unit_invol_grant = r_grant;
    assign o_param_data       = r_param_data;
    assign o_param_write      = r_param_write;
    assign o_rsp_done         = r_rsp_done;
    assign o_rsp_invol        = r_rsp_invol;
    assign o_rsp_err          = r_rsp_err;
    assign o_busy             = r_busy;

endmodule
